pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_if.sv | 18 +
 rtl/pwm_capture.sv | 94 +++++++++
 tb/tb_pwm_capture.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control, waveform input and measurement results of pwm_capture
interface pwm_capture_if #(parameter int CNT_W = 8);
    logic             i_ena;
    logic             i_pwm_in;
    logic [CNT_W-1:0] o_high_time;
    logic [CNT_W-1:0] o_period;
    logic             o_valid;
    logic             o_timeout;
    logic             o_stuck_level;
    modport master(
        output i_ena, i_pwm_in,
        input  o_high_time, o_period, o_valid, o_timeout, o_stuck_level
    );
    modport slave(
        input  i_ena, i_pwm_in,
        output o_high_time, o_period, o_valid, o_timeout, o_stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// flagging a timeout when no complete period arrives before the counters saturate.
module pwm_capture #(
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_high_cnt, r_per_cnt, r_high_time, r_period;
    logic             r_valid, r_timeout, r_stuck_level;
    logic             w_rise, w_fall, w_sat;
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_sat  = r_per_cnt == MAX;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            {r_s3, r_s2, r_s1} <= '0;
            r_high_cnt    <= '0;
            r_per_cnt     <= '0;
            r_high_time   <= '0;
            r_period      <= '0;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            {r_s3, r_s2, r_s1} <= {r_s2, r_s1, bus.i_pwm_in};
            r_valid <= 1'b0;
            if (!bus.i_ena) begin
                r_state    <= IDLE;
                r_high_cnt <= '0;
                r_per_cnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= w_rise ? HIGH : IDLE;
                        r_high_cnt <= w_rise ? ONE : '0;
                        r_per_cnt  <= w_rise ? ONE : '0;
                    end
                    HIGH: begin
                        // saturation beats a falling edge so per_cnt never wraps
                        if (w_sat) begin
                            r_state       <= IDLE;
                            r_high_cnt    <= '0;
                            r_per_cnt     <= '0;
                            r_timeout     <= 1'b1;
                            r_stuck_level <= r_s2;
                        end else begin
                            r_state    <= w_fall ? LOW : HIGH;
                            r_high_cnt <= w_fall ? r_high_cnt : r_high_cnt + ONE;
                            r_per_cnt  <= r_per_cnt + ONE;
                        end
                    end
                    LOW: begin
                        // a rising edge completes the period even at saturation
                        if (w_rise) begin
                            r_state     <= HIGH;
                            r_high_time <= r_high_cnt;
                            r_period    <= r_per_cnt;
                            r_valid     <= 1'b1;
                            r_timeout   <= 1'b0;
                            r_high_cnt  <= ONE;
                            r_per_cnt   <= ONE;
                        end else if (w_sat) begin
                            r_state       <= IDLE;
                            r_high_cnt    <= '0;
                            r_per_cnt     <= '0;
                            r_timeout     <= 1'b1;
                            r_stuck_level <= r_s2;
                        end else begin
                            r_per_cnt <= r_per_cnt + ONE;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_high_cnt <= '0;
                        r_per_cnt  <= '0;
                    end
                endcase
            end
        end
    end
    assign bus.o_high_time   = r_high_time;
    assign bus.o_period      = r_period;
    assign bus.o_valid       = r_valid;
    assign bus.o_timeout     = r_timeout;
    assign bus.o_stuck_level = r_stuck_level;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed waveforms with hand-computed measurements for pwm_capture
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_v = 0;
    int   gap = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   base = 0;
    pwm_capture_if #(.CNT_W(8)) bus();
    pwm_capture #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.o_valid) begin
            n_valid++;
            gap = cyc - last_v;
            last_v = cyc;
        end
    end
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic outs(input string tag, input int ht, input int pr, input int to, input int sl);
        check({tag, "_high_time"}, int'(bus.o_high_time), ht);
        check({tag, "_period"}, int'(bus.o_period), pr);
        check({tag, "_timeout"}, int'(bus.o_timeout), to);
        check({tag, "_stuck"}, int'(bus.o_stuck_level), sl);
    endtask
    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_pwm_in = v;
        end
    endtask
    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask
    task automatic quiesce();
        hold(1'b0, 4);
        bus.i_ena = 1'b0;
        hold(1'b0, 3);
        bus.i_ena = 1'b1;
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        hold(1'b0, 2);
        rst = 1'b0;
    endtask
    initial begin
        bus.i_ena = 1'b1;
        bus.i_pwm_in = 1'b0;
        hold(1'b0, 3);
        outs("reset", 0, 0, 0, 0);
        check("reset_valid", int'(bus.o_valid), 0);
        rst = 1'b0;
        // 3 high / 5 low
        hold(1'b0, 4);
        base = n_valid;
        wave(3, 5, 6);
        hold(1'b0, 4);
        check("w35_count", n_valid - base, 5);
        check("w35_gap", gap, 8);
        outs("w35", 3, 8, 0, 0);
        // 1 high / 1 low
        quiesce();
        base = n_valid;
        wave(1, 1, 10);
        hold(1'b0, 6);
        check("w11_count", n_valid - base, 9);
        check("w11_gap", gap, 2);
        outs("w11", 1, 2, 0, 0);
        // stuck high
        quiesce();
        base = n_valid;
        hold(1'b1, 240);
        check("hi240_timeout", int'(bus.o_timeout), 0);
        hold(1'b1, 60);
        outs("stuck_hi", 1, 2, 1, 1);
        check("stuck_hi_count", n_valid - base, 0);
        hold(1'b0, 4);
        wave(4, 4, 1);
        check("restart_first_count", n_valid - base, 0);
        check("restart_first_timeout", int'(bus.o_timeout), 1);
        wave(4, 4, 1);
        hold(1'b0, 4);
        check("restart_count", n_valid - base, 1);
        outs("restart", 4, 8, 0, 1);
        // stuck low after a full period
        hold(1'b0, 300);
        outs("stuck_lo", 4, 8, 1, 0);
        check("stuck_lo_count", n_valid - base, 1);
        // reset mid-HIGH of a 10/10 waveform
        pulse_rst();
        wave(10, 10, 2);
        hold(1'b1, 5);
        outs("pre_rst", 10, 20, 0, 0);
        rst = 1'b1;
        hold(1'b1, 1);
        rst = 1'b0;
        outs("mid_rst", 0, 0, 0, 0);
        check("mid_rst_valid", int'(bus.o_valid), 0);
        base = n_valid;
        hold(1'b1, 4);
        hold(1'b0, 10);
        check("post_rst_partial", n_valid - base, 0);
        wave(10, 10, 2);
        hold(1'b0, 4);
        check("post_rst_count", n_valid - base, 2);
        outs("post_rst", 10, 20, 0, 0);
        // enable dropped during a 2/6 waveform
        pulse_rst();
        base = n_valid;
        wave(2, 6, 3);
        hold(1'b0, 2);
        check("ena_pre_count", n_valid - base, 2);
        outs("ena_pre", 2, 8, 0, 0);
        bus.i_ena = 1'b0;
        base = n_valid;
        wave(3, 3, 8);
        hold(1'b0, 2);
        check("ena_off_count", n_valid - base, 0);
        outs("ena_off", 2, 8, 0, 0);
        bus.i_ena = 1'b1;
        wave(2, 6, 1);
        check("ena_first_rise", n_valid - base, 0);
        wave(2, 6, 1);
        hold(1'b0, 4);
        check("ena_resume_count", n_valid - base, 1);
        outs("ena_resume", 2, 8, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
